my_timer_led_blinker: RTL and testbench
=======================================

// Module: my_timer_led_blinker
// PURPOSE
//  Downstream consumer of the 1-bit PIO output port in the NIOS II timer system.
//  Takes the software-controlled enable bit and drives an LED with a fixed on/off blink pattern.
//  Keeps a saturating count of completed on-phases.
//  Sits between the PIO out_port and the board LED pin; everything is in the single system clock domain.
// PARAMETERS
//  ON_CYCLES   25_000_000  clocks LED is high per blink; 1 <= ON_CYCLES < 2**CNT_W
//  OFF_CYCLES  25_000_000  clocks LED is low per blink; 1 <= OFF_CYCLES < 2**CNT_W
//  CNT_W       26          width of the phase counter
//  BLINK_W     16          width of blink_count
//  Out-of-range ON_CYCLES or OFF_CYCLES is an elaboration-time error.
// PORTS
//  clk          in   1        system clock
//  reset        in   1        asynchronous, active-high reset
//  enable       in   1        blink request; driven by PIO out_port; synchronous to clk
//  led          out  1        registered LED drive, 1 = on
//  busy         out  1        registered, 1 while a blink period is in progress
//  blink_count  out  BLINK_W  registered, number of completed on-phases; saturating
// BEHAVIOUR
//  Reset:
//   - Asserting reset forces state=IDLE, led=0, busy=0, cnt=0, blink_count=0 immediately.
//   - Effect does not wait for a clk edge.
//   - Deassertion takes effect at the next clk edge.
//  FSM states: IDLE, ON, OFF. All outputs are registered:
//   - led  = (state==ON)
//   - busy = (state!=IDLE)
//  IDLE:
//   - enable=1 at edge k -> state=ON, cnt=0, led=1 and busy=1 from edge k.
//   - Latency is one clock.
//  ON:
//   - cnt increments each edge.
//   - At cnt==ON_CYCLES-1: state=OFF, cnt=0, blink_count+1.
//   - led is therefore high for exactly ON_CYCLES clocks.
//  OFF:
//   - cnt increments each edge.
//   - At cnt==OFF_CYCLES-1: enable=1 -> ON (cnt=0); enable=0 -> IDLE.
//   - led is low for exactly OFF_CYCLES clocks.
//  Enable handling:
//   - enable is sampled only in IDLE and on the last OFF cycle; it is ignored elsewhere.
//   - A started blink always completes a full ON plus full OFF period.
//   - A 1-cycle enable pulse in IDLE yields exactly one blink.
//   - Continuous enable gives back-to-back periods with no IDLE gap.
//  blink_count:
//   - Saturates at all-ones; it never wraps.
//   - Cleared only by reset.
//  ON_CYCLES=1 or OFF_CYCLES=1 is legal and gives single-clock phases.
// TESTING  (ON_CYCLES=4, OFF_CYCLES=3, BLINK_W=2)
//  1. Reset held, enable=1 -> led=0, busy=0, blink_count=0; first edge after release -> led=1.
//  2. enable held 1 -> led 1111000 repeating, no gap; blink_count 1,2,3 at end of each ON.
//  3. 1-cycle enable pulse in IDLE -> led 4 high, 3 low; then busy=0, blink_count=1.
//  4. enable dropped on 2nd ON clock -> ON still lasts 4, OFF lasts 3, then IDLE.
//  5. reset pulsed mid-ON, between edges -> led=0, busy=0, count=0 without a clk edge.
//  6. enable held for 5 blinks -> blink_count saturates at 3 and stays 3.

Source files
------------

// File: rtl/my_timer_led_blinker.sv
// LED blinker driven by the PIO enable bit: fixed ON/OFF pattern,
// registered outputs and a saturating count of completed on-phases.
module my_timer_led_blinker #(
    parameter int ON_CYCLES  = 25_000_000,
    parameter int OFF_CYCLES = 25_000_000,
    parameter int CNT_W      = 26,
    parameter int BLINK_W    = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    output logic               led,
    output logic               busy,
    output logic [BLINK_W-1:0] blink_count
);

    generate
        if (ON_CYCLES < 1 || (ON_CYCLES >> CNT_W) != 0) begin : g_bad_on
            $error("ON_CYCLES out of range for CNT_W");
        end
        if (OFF_CYCLES < 1 || (OFF_CYCLES >> CNT_W) != 0) begin : g_bad_off
            $error("OFF_CYCLES out of range for CNT_W");
        end
    endgenerate

    localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(OFF_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic [BLINK_W-1:0] count_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        count_d = blink_count;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (enable) begin
                    state_d = ON;
                end
            end
            ON: begin
                if (cnt_q == ON_LAST) begin
                    state_d = OFF;
                    cnt_d   = '0;
                    if (blink_count != '1) begin
                        count_d = blink_count + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            OFF: begin
                if (cnt_q == OFF_LAST) begin
                    state_d = enable ? ON : IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they track it exactly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            led         <= 1'b0;
            busy        <= 1'b0;
            blink_count <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            led         <= (state_d == ON);
            busy        <= (state_d != IDLE);
            blink_count <= count_d;
        end
    end

endmodule

// File: tb/tb_my_timer_led_blinker.sv
// Directed bench for my_timer_led_blinker with ON=4, OFF=3, BLINK_W=2.
module tb_my_timer_led_blinker;

    localparam int BW = 2;

    typedef struct {
        logic [BW+1:0] val;
        string         tag;
    } exp_t;

    logic          clk;
    logic          reset;
    logic          enable;
    logic          led;
    logic          busy;
    logic [BW-1:0] blink_count;

    exp_t sb[$];
    int   vectors;
    int   miscompares;

    my_timer_led_blinker #(
        .ON_CYCLES (4),
        .OFF_CYCLES(3),
        .CNT_W     (4),
        .BLINK_W   (BW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .led        (led),
        .busy       (busy),
        .blink_count(blink_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic push(input logic l, input logic b,
                        input logic [BW-1:0] c, input string tag);
        exp_t e;
        e.val = {l, b, c};
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic check();
        exp_t e;
        logic [BW+1:0] obs;
        e = sb.pop_front();
        obs = {led, busy, blink_count};
        vectors++;
        assert (obs === e.val) else begin
            miscompares++;
            $error("FAIL %s: led/busy/count observed %b/%b/%0d expected %b/%b/%0d",
                   e.tag, obs[BW+1], obs[BW], obs[BW-1:0],
                   e.val[BW+1], e.val[BW], e.val[BW-1:0]);
        end
    endtask

    task automatic cyc(input logic en, input logic l, input logic b,
                       input logic [BW-1:0] c, input string tag);
        enable = en;
        push(l, b, c, tag);
        @(posedge clk);
        #1;
        check();
    endtask

    // Reset pulse placed between edges; outputs must clear with no edge.
    task automatic reset_pulse(input string tag);
        reset = 1'b1;
        push(1'b0, 1'b0, '0, tag);
        #1;
        check();
        #2;
        reset = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        enable      = 1'b1;

        // 1: reset held with enable high
        #12;
        push(1'b0, 1'b0, '0, "reset_hold");
        check();
        #1;
        reset = 1'b0;
        cyc(1, 1, 1, 0, "first_edge_on");

        // 2: continuous enable, three periods, drop during third OFF
        for (int p = 1; p <= 3; p++) begin
            for (int i = (p == 1) ? 1 : 0; i < 4; i++)
                cyc(1, 1, 1, BW'(p - 1), "cont_on");
            for (int i = 0; i < 3; i++)
                cyc(p < 3, 0, 1, BW'(p), "cont_off");
        end
        cyc(0, 0, 0, 3, "cont_idle");

        reset_pulse("reset_between");

        // 3: single-cycle enable pulse
        cyc(1, 1, 1, 0, "pulse_on");
        for (int i = 0; i < 3; i++) cyc(0, 1, 1, 0, "pulse_on");
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 1, "pulse_off");
        cyc(0, 0, 0, 1, "pulse_idle");
        cyc(0, 0, 0, 1, "pulse_idle2");

        // 4: enable dropped on 2nd ON clock
        cyc(1, 1, 1, 1, "drop_on");
        for (int i = 0; i < 3; i++) cyc(0, 1, 1, 1, "drop_on");
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 2, "drop_off");
        cyc(0, 0, 0, 2, "drop_idle");

        // 5: reset mid-ON between edges
        cyc(1, 1, 1, 2, "mid_on");
        cyc(1, 1, 1, 2, "mid_on");
        reset_pulse("reset_mid_on");

        // 6: five blinks, count saturates at 3
        for (int p = 1; p <= 5; p++) begin
            for (int i = 0; i < 4; i++)
                cyc(1, 1, 1, BW'((p - 1 > 3) ? 3 : p - 1), "sat_on");
            for (int i = 0; i < 3; i++)
                cyc(p < 5, 0, 1, BW'((p > 3) ? 3 : p), "sat_off");
        end
        cyc(0, 0, 0, 3, "sat_idle");
        cyc(0, 0, 0, 3, "sat_hold");

        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d left, expected 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
